// File: rtl/e203_soc_top.sv
// Tiny instruction-driven SoC: a sequencer runs a preloaded ITCM program that
// loads a 3x3 weight/pixel set and drives a serial multiply-accumulate engine.
module e203_soc_top #(
  parameter int ITCM_DP = 256
) (
  input  logic        hfclk,
  input  logic        rst_n,
  output logic        conv_irq,
  output logic [19:0] conv_result,
  output logic        halted,
  output logic        illegal
);

  localparam int AW = (ITCM_DP > 1) ? $clog2(ITCM_DP) : 1;
  localparam logic [AW-1:0] PC_LAST = AW'(ITCM_DP - 1);

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_START = 8'h02;
  localparam logic [7:0] OP_WAIT  = 8'h03;
  localparam logic [7:0] OP_HALT  = 8'h04;

  localparam logic [7:0] ADDR_IRQ_CLR = 8'h20;

  typedef enum logic [1:0] {FETCH, EXEC, WAIT, HALT} state_t;

  // Program memory, filled from outside by hierarchical preload.
  logic [63:0] mem_r [0:ITCM_DP-1];

  state_t      state_reg, state_next;
  logic [AW-1:0] pc_reg;
  logic [63:0] instr_reg;
  logic        illegal_reg;

  logic [7:0]  w_reg [0:8];
  logic [7:0]  p_reg [0:8];

  logic        start_pend_reg;
  logic        busy_reg;
  logic [3:0]  k_reg;
  logic [19:0] acc_reg;
  logic [19:0] result_reg;
  logic        irq_reg;

  logic [7:0]  opcode;
  logic [7:0]  reg_addr;
  logic [7:0]  wdata;
  logic        instr_unused;

  logic        pc_adv;
  logic        reg_we;
  logic        start_cmd;
  logic        illegal_set;
  logic        halted_out;

  logic signed [15:0] prod;
  logic [19:0] acc_sum;
  logic        done;
  logic        irq_clr;

  assign opcode       = instr_reg[63:56];
  assign reg_addr     = instr_reg[55:48];
  assign wdata        = instr_reg[7:0];
  assign instr_unused = ^instr_reg[47:8];

  // ---------------- sequencer ----------------
  always_ff @(posedge hfclk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FETCH: state_next = EXEC;
      EXEC: begin
        case (opcode)
          OP_NOP, OP_WRITE, OP_START: state_next = FETCH;
          OP_WAIT:                    state_next = WAIT;
          default:                    state_next = HALT;
        endcase
      end
      // A START still in flight counts as busy so WAIT cannot slip past it.
      WAIT:    state_next = (busy_reg || start_pend_reg) ? WAIT : FETCH;
      HALT:    state_next = HALT;
      default: state_next = FETCH;
    endcase
  end

  always_comb begin
    pc_adv      = 1'b0;
    reg_we      = 1'b0;
    start_cmd   = 1'b0;
    illegal_set = 1'b0;
    halted_out  = (state_reg == HALT);
    if (state_reg == EXEC) begin
      case (opcode)
        OP_NOP:   pc_adv = 1'b1;
        OP_WRITE: begin
          pc_adv = 1'b1;
          reg_we = 1'b1;
        end
        OP_START: begin
          pc_adv    = 1'b1;
          start_cmd = 1'b1;
        end
        OP_WAIT:  pc_adv = 1'b1;
        OP_HALT:  pc_adv = 1'b0;
        default:  illegal_set = 1'b1;
      endcase
    end
  end

  // Registered ITCM read; no reset so the array maps onto block RAM.
  always_ff @(posedge hfclk) begin
    if (state_reg == FETCH) begin
      instr_reg <= mem_r[pc_reg];
    end
  end

  always_ff @(posedge hfclk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg      <= '0;
      illegal_reg <= 1'b0;
    end else begin
      if (pc_adv) begin
        pc_reg <= (pc_reg == PC_LAST) ? '0 : pc_reg + 1'b1;
      end
      if (illegal_set) begin
        illegal_reg <= 1'b1;
      end
    end
  end

  // ---------------- register file ----------------
  generate
    for (genvar gi = 0; gi < 9; gi++) begin : g_regs
      always_ff @(posedge hfclk or negedge rst_n) begin
        if (!rst_n) begin
          w_reg[gi] <= '0;
          p_reg[gi] <= '0;
        end else if (reg_we) begin
          if (reg_addr == 8'(gi)) begin
            w_reg[gi] <= wdata;
          end
          if (reg_addr == 8'(gi + 16)) begin
            p_reg[gi] <= wdata;
          end
        end
      end
    end
  endgenerate

  assign irq_clr = reg_we && (reg_addr == ADDR_IRQ_CLR);

  // ---------------- MAC engine ----------------
  assign prod    = $signed(w_reg[k_reg]) * $signed(p_reg[k_reg]);
  assign acc_sum = acc_reg + {{4{prod[15]}}, prod};
  assign done    = busy_reg && (k_reg == 4'd8);

  // START is registered once so busy rises one edge after the START EXEC.
  always_ff @(posedge hfclk or negedge rst_n) begin
    if (!rst_n) begin
      start_pend_reg <= 1'b0;
      busy_reg       <= 1'b0;
      k_reg          <= '0;
      acc_reg        <= '0;
      result_reg     <= '0;
    end else begin
      start_pend_reg <= start_cmd;
      if (busy_reg) begin
        acc_reg <= acc_sum;
        if (done) begin
          busy_reg   <= 1'b0;
          result_reg <= acc_sum;
        end else begin
          k_reg <= k_reg + 4'd1;
        end
      end else if (start_pend_reg) begin
        busy_reg <= 1'b1;
        acc_reg  <= '0;
        k_reg    <= '0;
      end
    end
  end

  // Completion has priority over a same-edge clear.
  always_ff @(posedge hfclk or negedge rst_n) begin
    if (!rst_n) begin
      irq_reg <= 1'b0;
    end else if (done) begin
      irq_reg <= 1'b1;
    end else if (irq_clr) begin
      irq_reg <= 1'b0;
    end
  end

  assign conv_irq    = irq_reg;
  assign conv_result = result_reg;
  assign halted      = halted_out;
  assign illegal     = illegal_reg;

endmodule

// File: tb/tb_e203_soc_top.sv
// Scoreboard bench: each program pushes its expected convolution result, the
// monitor pops and compares it on every rising edge of conv_irq.
module tb_e203_soc_top;

  logic        hfclk;
  logic        rst_n;
  logic        conv_irq;
  logic [19:0] conv_result;
  logic        halted;
  logic        illegal;

  e203_soc_top #(.ITCM_DP(256)) dut (
    .hfclk       (hfclk),
    .rst_n       (rst_n),
    .conv_irq    (conv_irq),
    .conv_result (conv_result),
    .halted      (halted),
    .illegal     (illegal)
  );

  initial hfclk = 1'b0;
  always #5 hfclk = ~hfclk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rise_count = 0;
  int rise_cyc = -1;
  int fall_cyc = -1;
  logic irq_prev = 1'b0;

  logic [19:0] exp_q [$];
  logic [63:0] prog [$];
  logic [7:0]  tw [0:8];
  logic [7:0]  tp [0:8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ins(input logic [7:0] op, input logic [7:0] addr,
                                      input logic [31:0] data);
    return {op, addr, 16'h0000, data};
  endfunction

  function automatic logic [19:0] model_sum();
    int s;
    logic [19:0] r;
    s = 0;
    for (int i = 0; i < 9; i++) begin
      s += int'($signed(tw[i])) * int'($signed(tp[i]));
    end
    r = s[19:0];
    return r;
  endfunction

  // Words 0..17 load w0..w8 then p0..p8 from tw/tp.
  task automatic build_loads();
    prog.delete();
    for (int i = 0; i < 9; i++) prog.push_back(ins(8'h01, 8'(i), {24'h0, tw[i]}));
    for (int i = 0; i < 9; i++) prog.push_back(ins(8'h01, 8'(i + 16), {24'h0, tp[i]}));
  endtask

  task automatic load_mem();
    for (int i = 0; i < 256; i++) dut.mem_r[i] = ins(8'h04, 8'h00, 32'h0);
    for (int i = 0; i < prog.size(); i++) dut.mem_r[i] = prog[i];
  endtask

  task automatic do_reset_and_run();
    rst_n = 1'b0;
    @(negedge hfclk);
    load_mem();
    @(negedge hfclk);
    rise_count = 0;
    rise_cyc   = -1;
    fall_cyc   = -1;
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  task automatic wait_halt(input string tag);
    int n;
    n = 0;
    while (!halted && n < 300) begin
      @(negedge hfclk);
      n++;
    end
    if (!halted) check({tag, "_timeout"}, 32'(n), 32'd0);
  endtask

  initial forever @(posedge hfclk) cyc++;

  // Output monitor, sampling on the falling edge.
  initial forever begin
    @(negedge hfclk);
    if (rst_n) begin
      if (conv_irq && !irq_prev) begin
        rise_count++;
        rise_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("spurious_irq", {12'h0, conv_result}, 32'hFFFFFFFF);
        end else begin
          logic [19:0] e;
          e = exp_q.pop_front();
          $display("txn: completion cyc=%0d result=%05h expected=%05h", cyc, conv_result, e);
          check("conv_result", {12'h0, conv_result}, {12'h0, e});
        end
      end
      if (!conv_irq && irq_prev) fall_cyc = cyc;
      irq_prev = conv_irq;
    end else begin
      irq_prev = 1'b0;
    end
  end

  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge hfclk);
    check("rst_irq", {31'h0, conv_irq}, 32'd0);
    check("rst_result", {12'h0, conv_result}, 32'd0);
    check("rst_halted", {31'h0, halted}, 32'd0);
    check("rst_illegal", {31'h0, illegal}, 32'd0);

    // Basic program: 1*1+..+1*9 = 45, irq 10 cycles after START EXEC (edge 38).
    for (int i = 0; i < 9; i++) begin tw[i] = 8'h01; tp[i] = 8'(i + 1); end
    build_loads();
    prog.push_back(ins(8'h02, 8'h00, 32'h0));
    prog.push_back(ins(8'h03, 8'h00, 32'h0));
    prog.push_back(ins(8'h04, 8'h00, 32'h0));
    exp_q.push_back(model_sum());
    do_reset_and_run();
    wait_halt("basic");
    check("basic_latency", 32'(rise_cyc), 32'd48);
    check("basic_halt_cyc", 32'(cyc), 32'd51);
    check("basic_halted", {31'h0, halted}, 32'd1);
    check("basic_illegal", {31'h0, illegal}, 32'd0);
    check("basic_irq", {31'h0, conv_irq}, 32'd1);
    check("basic_value", {12'h0, conv_result}, 32'h0002D);

    // Negative products: -1 * 127 * 9.
    for (int i = 0; i < 9; i++) begin tw[i] = 8'hFF; tp[i] = 8'h7F; end
    build_loads();
    prog.push_back(ins(8'h02, 8'h00, 32'h0));
    prog.push_back(ins(8'h03, 8'h00, 32'h0));
    prog.push_back(ins(8'h04, 8'h00, 32'h0));
    exp_q.push_back(model_sum());
    do_reset_and_run();
    wait_halt("neg");
    check("neg_value", {12'h0, conv_result}, 32'hFFB89);

    // Extreme magnitude, then IRQ clear after WAIT.
    for (int i = 0; i < 9; i++) begin tw[i] = 8'h80; tp[i] = 8'h80; end
    build_loads();
    prog.push_back(ins(8'h02, 8'h00, 32'h0));
    prog.push_back(ins(8'h03, 8'h00, 32'h0));
    prog.push_back(ins(8'h01, 8'h20, 32'h0));
    prog.push_back(ins(8'h04, 8'h00, 32'h0));
    exp_q.push_back(model_sum());
    do_reset_and_run();
    wait_halt("max");
    check("max_value", {12'h0, conv_result}, 32'h24000);
    check("clr_irq", {31'h0, conv_irq}, 32'd0);
    check("clr_fall_cyc", 32'(fall_cyc), 32'd51);

    // Reset 4 cycles after START aborts; the rerun completes normally.
    for (int i = 0; i < 9; i++) begin tw[i] = 8'h01; tp[i] = 8'(i + 1); end
    build_loads();
    prog.push_back(ins(8'h02, 8'h00, 32'h0));
    prog.push_back(ins(8'h03, 8'h00, 32'h0));
    prog.push_back(ins(8'h04, 8'h00, 32'h0));
    exp_q.push_back(model_sum());
    do_reset_and_run();
    while (cyc < 42) @(negedge hfclk);
    rst_n = 1'b0;
    #1;
    check("abort_irq", {31'h0, conv_irq}, 32'd0);
    check("abort_result", {12'h0, conv_result}, 32'd0);
    check("abort_halted", {31'h0, halted}, 32'd0);
    repeat (3) @(negedge hfclk);
    check("abort_rise_count", 32'(rise_count), 32'd0);
    rst_n = 1'b1;
    cyc   = 0;
    wait_halt("rerun");
    check("rerun_latency", 32'(rise_cyc), 32'd48);
    check("rerun_value", {12'h0, conv_result}, 32'h0002D);

    // Undefined opcode at word 3; a START follows but must never run.
    prog.delete();
    prog.push_back(ins(8'h01, 8'h00, 32'h5));
    prog.push_back(ins(8'h01, 8'h10, 32'h5));
    prog.push_back(ins(8'h00, 8'h00, 32'h0));
    prog.push_back(ins(8'h7E, 8'h00, 32'h0));
    prog.push_back(ins(8'h02, 8'h00, 32'h0));
    prog.push_back(ins(8'h03, 8'h00, 32'h0));
    do_reset_and_run();
    wait_halt("ill");
    check("ill_halt_cyc", 32'(cyc), 32'd8);
    check("ill_illegal", {31'h0, illegal}, 32'd1);
    repeat (20) @(negedge hfclk);
    check("ill_no_irq", 32'(rise_count), 32'd0);
    check("ill_result", {12'h0, conv_result}, 32'd0);

    // Second START 3 cycles into the run is ignored: one completion only.
    for (int i = 0; i < 9; i++) begin
      tw[i] = 8'($urandom_range(0, 255));
      tp[i] = 8'($urandom_range(0, 255));
    end
    build_loads();
    prog.push_back(ins(8'h02, 8'h00, 32'h0));
    prog.push_back(ins(8'h00, 8'h00, 32'h0));
    prog.push_back(ins(8'h02, 8'h00, 32'h0));
    prog.push_back(ins(8'h03, 8'h00, 32'h0));
    prog.push_back(ins(8'h04, 8'h00, 32'h0));
    exp_q.push_back(model_sum());
    do_reset_and_run();
    wait_halt("dbl");
    repeat (15) @(negedge hfclk);
    check("dbl_rise_count", 32'(rise_count), 32'd1);
    check("dbl_latency", 32'(rise_cyc), 32'd48);

    // Write to p8 while busy: the not-yet-accumulated term sees the new value.
    for (int i = 0; i < 9; i++) begin tw[i] = 8'h01; tp[i] = 8'(i + 1); end
    build_loads();
    prog.push_back(ins(8'h02, 8'h00, 32'h0));
    prog.push_back(ins(8'h01, 8'h18, 32'd100));
    prog.push_back(ins(8'h03, 8'h00, 32'h0));
    prog.push_back(ins(8'h04, 8'h00, 32'h0));
    tp[8] = 8'd100;
    exp_q.push_back(model_sum());
    do_reset_and_run();
    wait_halt("live");
    check("live_value", {12'h0, conv_result}, 32'd136);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got %0d expected 0", checks);
    $fatal(1, "timeout");
  end

endmodule
